fm_sb_freeze_seq: RTL and testbench
===================================

Name: fm_sb_freeze_seq

Overview:
Trigger-driven freeze sequencer for the fast-monitor spy buffers. Software arms the sequencer. A software or external trigger then starts a programmable post-trigger delay. When the delay expires, the per-buffer freeze lines are asserted for every spy buffer not masked. The freeze is held until software releases it. It sits between the AXI control registers and the spy-buffer freeze inputs. It replaces a direct level-driven global freeze with a captured, timestamped event.

Parameters:
TOTAL_SB, 8, number of spy buffers driven
CNT_W, 16, width of post-trigger delay counter
TS_W, 32, width of free-running timestamp

Ports:
axi_clk  in  1  sole clock
axi_rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse: arm sequencer
release_i  in  1  single-cycle pulse: drop freeze / abort, return to IDLE
sw_trig  in  1  single-cycle software trigger pulse
ext_trig  in  1  external trigger level, already synchronous to axi_clk
ext_trig_en  in  1  enables ext_trig rising-edge detection
post_trig_len  in  CNT_W  cycles from trigger to freeze
freeze_mask  in  TOTAL_SB  1 = buffer excluded from freeze
freeze  out  TOTAL_SB  per-buffer freeze
state_o  out  2  0 IDLE, 1 ARMED, 2 POST_TRIG, 3 FROZEN
trig_ts  out  TS_W  timestamp captured at accepted trigger
trig_src  out  1  0 = software, 1 = external, for last accepted trigger
trig_cnt  out  8  accepted-trigger count, saturating at 255

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, timestamp 0, ext_trig edge register 0, latched mask 0.
- Timestamp: free-running counter, +1 per cycle, wraps to 0 modulo 2^TS_W.
- Trigger event at cycle T: sw_trig=1, OR (ext_trig_en=1 AND ext_trig=1 at T AND ext_trig=0 at T-1).
  - The edge register tracks ext_trig in every state, whether or not ext_trig_en is set.
  - If both sources fire in the same cycle, trig_src=0 (software wins).
- IDLE:
  - arm -> ARMED.
  - Triggers are ignored.
- ARMED, on a trigger at T:
  - Capture trig_ts = timestamp at T.
  - Capture trig_src.
  - Increment trig_cnt.
  - Latch freeze_mask.
  - If post_trig_len==0 -> FROZEN. Otherwise -> POST_TRIG with the delay counter loaded with post_trig_len.
- POST_TRIG:
  - Counter decrements each cycle.
  - When counter==1 -> FROZEN.
  - Further triggers are ignored.
- FROZEN:
  - freeze = ~latched_mask, registered.
  - Rising edge of freeze occurs at clock edge T+1+post_trig_len.
  - Held until release_i.
- release_i in any non-IDLE state:
  - Next cycle: state IDLE, freeze all 0.
  - trig_ts, trig_src and trig_cnt are retained.
- Simultaneous arm and release_i: release wins (-> IDLE).
- Simultaneous arm and trigger while in IDLE: go to ARMED only; the trigger is discarded.
- arm while in ARMED, POST_TRIG or FROZEN: no effect.
- post_trig_len and freeze_mask changes after the trigger do not affect the in-flight event; values are latched at the trigger.
- Outputs are registered; there is no combinational path from any input to any output.
- Async reset mid-operation (any state): immediate return to reset values; freeze drops without waiting for a clock.

Decomposition:
- Add to fm_sb_pkg:
  - seq_state_t enum (IDLE/ARMED/POST_TRIG/FROZEN, 2 bits).
  - TRIG_SRC_SW / TRIG_SRC_EXT constants.
  - Default TOTAL_SB tied to the package total_sb.
- One natural sub-module: fm_sb_trig_detect. It holds the ext_trig edge register, source priority, and the enable gate; it outputs a trig pulse and src.
- The FSM, delay counter, timestamp and capture registers stay in the top module.

Test Plan:
- Basic: reset, arm, post_trig_len=10, sw_trig at timestamp 100 -> state POST_TRIG, freeze=0xFF rises 11 cycles after trigger, trig_ts=100, trig_src=0, trig_cnt=1; release -> freeze=0 next cycle, state IDLE.
- Zero delay and mask: freeze_mask=0x0F, post_trig_len=0, ext_trig_en=1, ext_trig rises -> freeze=0xF0 on the following edge, trig_src=1. Then change freeze_mask to 0x00 while FROZEN -> freeze stays 0xF0.
- Edge and enable: ext_trig held high before arm with ext_trig_en=1 -> no trigger after arm. ext_trig_en=0 with a rising edge -> no trigger. Triggers in IDLE -> trig_cnt unchanged.
- Collisions:
  - sw_trig and an ext edge in the same cycle -> trig_src=0.
  - arm and release_i together in ARMED -> IDLE.
  - Second sw_trig during POST_TRIG -> trig_ts and trig_cnt unchanged.
- Abort and reset:
  - release_i mid POST_TRIG with len=1000 -> IDLE, freeze never asserts.
  - axi_rst_n low while FROZEN -> freeze=0 asynchronously, state_o=0, trig_cnt=0.
- Wrap and saturation:
  - Run with TS_W=8 past 255 -> timestamp wraps to 0 and the captured trig_ts is correct.
  - 300 arm/trigger/release cycles -> trig_cnt=255.

Source files
------------

// File: rtl/fm_sb_pkg.sv
// Shared types and constants for the fast-monitor spy-buffer control slice.
package fm_sb_pkg;

  localparam int total_sb = 8;

  localparam logic TRIG_SRC_SW  = 1'b0;
  localparam logic TRIG_SRC_EXT = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    POST_TRIG = 2'd2,
    FROZEN    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fm_sb_freeze_seq_if.sv
// Control/status bundle between the AXI register block and the freeze sequencer.
// Control inputs are single-cycle pulses or levels sampled on axi_clk; there is no
// valid/ready handshake, so every input is acted on in the cycle it is seen.
interface fm_sb_freeze_seq_if #(
  parameter int TOTAL_SB = 8,
  parameter int CNT_W    = 16,
  parameter int TS_W     = 32
);
  logic                arm;
  logic                release_i;
  logic                sw_trig;
  logic                ext_trig;
  logic                ext_trig_en;
  logic [CNT_W-1:0]    post_trig_len;
  logic [TOTAL_SB-1:0] freeze_mask;
  logic [TOTAL_SB-1:0] freeze;
  logic [1:0]          state_o;
  logic [TS_W-1:0]     trig_ts;
  logic                trig_src;
  logic [7:0]          trig_cnt;

  modport master (
    output arm, release_i, sw_trig, ext_trig, ext_trig_en, post_trig_len, freeze_mask,
    input  freeze, state_o, trig_ts, trig_src, trig_cnt
  );

  modport slave (
    input  arm, release_i, sw_trig, ext_trig, ext_trig_en, post_trig_len, freeze_mask,
    output freeze, state_o, trig_ts, trig_src, trig_cnt
  );
endinterface

// File: rtl/fm_sb_trig_detect.sv
// Trigger qualification: ext_trig rising-edge detect, enable gate, software priority.
module fm_sb_trig_detect
  import fm_sb_pkg::*;
(
  input  logic axi_clk,
  input  logic axi_rst_n,
  input  logic sw_trig,
  input  logic ext_trig,
  input  logic ext_trig_en,
  output logic trig,
  output logic trig_src
);

  logic ext_prev_q;
  logic ext_rise;

  // Tracks ext_trig unconditionally so a level already high at enable/arm time
  // never looks like a fresh edge.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      ext_prev_q <= 1'b0;
    end else begin
      ext_prev_q <= ext_trig;
    end
  end

  assign ext_rise = ext_trig_en & ext_trig & ~ext_prev_q;
  assign trig     = sw_trig | ext_rise;
  assign trig_src = sw_trig ? TRIG_SRC_SW : TRIG_SRC_EXT;

endmodule

// File: rtl/fm_sb_freeze_seq.sv
// Armed trigger -> programmable delay -> masked per-buffer freeze, held until release.
module fm_sb_freeze_seq
  import fm_sb_pkg::*;
#(
  parameter int TOTAL_SB = total_sb,
  parameter int CNT_W    = 16,
  parameter int TS_W     = 32
) (
  input  logic               axi_clk,
  input  logic               axi_rst_n,
  fm_sb_freeze_seq_if.slave  bus
);

  seq_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TS_W-1:0]     ts_q;
  logic [TS_W-1:0]     trig_ts_q;
  logic                trig_src_q;
  logic [7:0]          trig_cnt_q;
  logic [TOTAL_SB-1:0] mask_q;
  logic [TOTAL_SB-1:0] freeze_q;

  logic trig;
  logic trig_src_now;

  fm_sb_trig_detect u_trig_detect (
    .axi_clk     (axi_clk),
    .axi_rst_n   (axi_rst_n),
    .sw_trig     (bus.sw_trig),
    .ext_trig    (bus.ext_trig),
    .ext_trig_en (bus.ext_trig_en),
    .trig        (trig),
    .trig_src    (trig_src_now)
  );

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ts_q       <= '0;
      trig_ts_q  <= '0;
      trig_src_q <= 1'b0;
      trig_cnt_q <= '0;
      mask_q     <= '0;
      freeze_q   <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;

      case (state_q)
        IDLE: begin
          // Release beats arm; a trigger coinciding with arm is dropped.
          if (bus.arm && !bus.release_i) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (bus.release_i) begin
            state_q <= IDLE;
          end else if (trig) begin
            trig_ts_q  <= ts_q;
            trig_src_q <= trig_src_now;
            mask_q     <= bus.freeze_mask;
            if (trig_cnt_q != 8'hFF) begin
              trig_cnt_q <= trig_cnt_q + 1'b1;
            end
            if (bus.post_trig_len == '0) begin
              state_q <= FROZEN;
            end else begin
              cnt_q   <= bus.post_trig_len;
              state_q <= POST_TRIG;
            end
          end
        end
        POST_TRIG: begin
          if (bus.release_i) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_W'(1)) begin
            state_q <= FROZEN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FROZEN: begin
          if (bus.release_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // One cycle behind entry to FROZEN: rise lands T+1+post_trig_len after the trigger.
      freeze_q <= (state_q == FROZEN && !bus.release_i) ? ~mask_q : '0;
    end
  end

  assign bus.freeze   = freeze_q;
  assign bus.state_o  = state_q;
  assign bus.trig_ts  = trig_ts_q;
  assign bus.trig_src = trig_src_q;
  assign bus.trig_cnt = trig_cnt_q;

endmodule

// File: tb/tb_fm_sb_freeze_seq.sv
// Directed bench for the freeze sequencer, run with an 8-bit timestamp to exercise wrap.
module tb_fm_sb_freeze_seq;

  localparam int TOTAL_SB = 8;
  localparam int CNT_W    = 16;
  localparam int TS_W     = 8;

  typedef struct {
    logic [CNT_W-1:0]    len;
    logic [TOTAL_SB-1:0] mask;
    logic                sw;
    logic                ext;
    logic                en;
    logic [TOTAL_SB-1:0] exp_freeze;
    logic                exp_src;
  } vec_t;

  // clock / reset
  logic axi_clk   = 1'b0;
  logic axi_rst_n = 1'b0;
  always #5 axi_clk = ~axi_clk;

  fm_sb_freeze_seq_if #(.TOTAL_SB(TOTAL_SB), .CNT_W(CNT_W), .TS_W(TS_W)) bus ();

  fm_sb_freeze_seq #(.TOTAL_SB(TOTAL_SB), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .axi_clk   (axi_clk),
    .axi_rst_n (axi_rst_n),
    .bus       (bus)
  );

  // reference free-running timestamp
  logic [TS_W-1:0] tb_ts;
  always @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) tb_ts <= '0;
    else            tb_ts <= tb_ts + 1'b1;
  end

  // scoreboard
  logic [TS_W-1:0] exp_q[$];
  logic [7:0]      exp_cnt;
  int              errors = 0;
  int              checks = 0;
  vec_t            vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks (all called right after a negedge)
  task automatic step();
    @(negedge axi_clk);
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask

  task automatic pulse_release();
    bus.release_i = 1'b1;
    step();
    bus.release_i = 1'b0;
  endtask

  task automatic bump_cnt();
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 1'b1;
  endtask

  // accepted trigger: records expected timestamp, leaves ext_trig at its new level
  task automatic fire(input logic sw, input logic ext);
    bus.sw_trig = sw;
    if (ext) bus.ext_trig = 1'b1;
    exp_q.push_back(tb_ts);
    step();
    bus.sw_trig = 1'b0;
    bump_cnt();
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] target);
    bit hit = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (tb_ts == target) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    if (!hit) check("wait_ts_timeout", {24'd0, tb_ts}, {24'd0, target});
  endtask

  initial begin
    logic [TS_W-1:0] ts_first;

    vecs[0] = '{len: 16'd3, mask: 8'hA5, sw: 1'b1, ext: 1'b0, en: 1'b0, exp_freeze: 8'h5A, exp_src: 1'b0};
    vecs[1] = '{len: 16'd0, mask: 8'h0F, sw: 1'b0, ext: 1'b1, en: 1'b1, exp_freeze: 8'hF0, exp_src: 1'b1};
    vecs[2] = '{len: 16'd1, mask: 8'h00, sw: 1'b1, ext: 1'b1, en: 1'b1, exp_freeze: 8'hFF, exp_src: 1'b0};
    vecs[3] = '{len: 16'd5, mask: 8'hFF, sw: 1'b0, ext: 1'b1, en: 1'b1, exp_freeze: 8'h00, exp_src: 1'b1};
    vecs[4] = '{len: 16'd2, mask: 8'h3C, sw: 1'b1, ext: 1'b0, en: 1'b1, exp_freeze: 8'hC3, exp_src: 1'b0};

    bus.arm = 1'b0; bus.release_i = 1'b0; bus.sw_trig = 1'b0;
    bus.ext_trig = 1'b0; bus.ext_trig_en = 1'b0;
    bus.post_trig_len = '0; bus.freeze_mask = '0;
    exp_cnt = 8'd0;

    // reset values
    step(); step();
    check("rst_freeze",   bus.freeze,   0);
    check("rst_state",    bus.state_o,  0);
    check("rst_trig_ts",  bus.trig_ts,  0);
    check("rst_trig_src", bus.trig_src, 0);
    check("rst_trig_cnt", bus.trig_cnt, 0);
    axi_rst_n = 1'b1;
    step();

    // basic: len 10, sw trigger at timestamp 100
    bus.post_trig_len = 16'd10;
    pulse_arm();
    check("basic_armed", bus.state_o, 1);
    wait_ts(8'd100);
    fire(1'b1, 1'b0);
    check("basic_post_trig", bus.state_o, 2);
    check("basic_trig_ts",   bus.trig_ts, 100);
    void'(exp_q.pop_front());
    check("basic_trig_src",  bus.trig_src, 0);
    check("basic_trig_cnt",  bus.trig_cnt, 1);
    repeat (10) step();
    check("basic_freeze_early", bus.freeze, 8'h00);
    step();
    check("basic_freeze_rise",  bus.freeze, 8'hFF);
    check("basic_frozen",       bus.state_o, 3);
    pulse_release();
    check("basic_rel_freeze", bus.freeze, 0);
    check("basic_rel_state",  bus.state_o, 0);
    check("basic_rel_ts",     bus.trig_ts, 100);
    check("basic_rel_cnt",    bus.trig_cnt, 1);

    // table-driven vectors; len/mask are scrambled after the trigger to prove latching
    foreach (vecs[i]) begin
      bus.post_trig_len = vecs[i].len;
      bus.freeze_mask   = vecs[i].mask;
      bus.ext_trig_en   = vecs[i].en;
      pulse_arm();
      fire(vecs[i].sw, vecs[i].ext);
      bus.freeze_mask   = ~vecs[i].mask;
      bus.post_trig_len = 16'd7;
      check($sformatf("vec%0d_state", i), bus.state_o, (vecs[i].len == 0) ? 3 : 2);
      check($sformatf("vec%0d_ts", i),    bus.trig_ts, exp_q.pop_front());
      check($sformatf("vec%0d_src", i),   bus.trig_src, vecs[i].exp_src);
      check($sformatf("vec%0d_cnt", i),   bus.trig_cnt, exp_cnt);
      repeat (int'(vecs[i].len)) step();
      check($sformatf("vec%0d_freeze_early", i), bus.freeze, 8'h00);
      step();
      check($sformatf("vec%0d_freeze", i), bus.freeze, vecs[i].exp_freeze);
      pulse_release();
      check($sformatf("vec%0d_rel_freeze", i), bus.freeze, 0);
      check($sformatf("vec%0d_rel_state", i),  bus.state_o, 0);
      bus.ext_trig = 1'b0;
      step();
    end

    // zero delay, mask changed while FROZEN
    bus.post_trig_len = '0; bus.freeze_mask = 8'h0F; bus.ext_trig_en = 1'b1;
    pulse_arm();
    fire(1'b0, 1'b1);
    void'(exp_q.pop_front());
    step();
    check("zd_freeze", bus.freeze, 8'hF0);
    check("zd_src",    bus.trig_src, 1);
    bus.freeze_mask = 8'h00;
    repeat (3) step();
    check("zd_mask_hold", bus.freeze, 8'hF0);
    pulse_release();
    bus.ext_trig = 1'b0;
    step();

    // ext level high before arm: no edge after arming
    bus.ext_trig = 1'b1;
    step(); step();
    check("idle_ext_state", bus.state_o, 0);
    pulse_arm();
    repeat (3) step();
    check("lvl_no_trig_state", bus.state_o, 1);
    check("lvl_no_trig_cnt",   bus.trig_cnt, exp_cnt);
    // edge with enable low
    bus.ext_trig = 1'b0; bus.ext_trig_en = 1'b0;
    step();
    bus.ext_trig = 1'b1;
    step(); step();
    check("en_off_state", bus.state_o, 1);
    check("en_off_cnt",   bus.trig_cnt, exp_cnt);
    pulse_release();
    bus.ext_trig = 1'b0;
    // sw trigger in IDLE ignored
    bus.sw_trig = 1'b1; step(); bus.sw_trig = 1'b0;
    check("idle_trig_state", bus.state_o, 0);
    check("idle_trig_cnt",   bus.trig_cnt, exp_cnt);
    // arm + trigger together in IDLE -> ARMED only
    bus.arm = 1'b1; bus.sw_trig = 1'b1; step(); bus.arm = 1'b0; bus.sw_trig = 1'b0;
    check("arm_trig_state", bus.state_o, 1);
    check("arm_trig_cnt",   bus.trig_cnt, exp_cnt);
    // arm + release in ARMED -> IDLE
    bus.arm = 1'b1; bus.release_i = 1'b1; step(); bus.arm = 1'b0; bus.release_i = 1'b0;
    check("arm_rel_state", bus.state_o, 0);

    // second trigger during POST_TRIG ignored
    bus.post_trig_len = 16'd20;
    pulse_arm();
    ts_first = tb_ts;
    fire(1'b1, 1'b0);
    check("retrig_ts0", bus.trig_ts, exp_q.pop_front());
    repeat (3) step();
    bus.sw_trig = 1'b1; step(); bus.sw_trig = 1'b0;
    check("retrig_ts",    bus.trig_ts, ts_first);
    check("retrig_cnt",   bus.trig_cnt, exp_cnt);
    check("retrig_state", bus.state_o, 2);
    pulse_release();

    // abort mid POST_TRIG
    bus.post_trig_len = 16'd1000;
    pulse_arm();
    fire(1'b1, 1'b0);
    void'(exp_q.pop_front());
    repeat (50) step();
    pulse_release();
    check("abort_state", bus.state_o, 0);
    repeat (20) step();
    check("abort_freeze", bus.freeze, 0);

    // timestamp wrap
    bus.post_trig_len = '0; bus.freeze_mask = '0;
    pulse_arm();
    wait_ts(8'd255);
    fire(1'b1, 1'b0);
    void'(exp_q.pop_front());
    check("wrap_ts_255", bus.trig_ts, 255);
    pulse_release();
    pulse_arm();
    wait_ts(8'd3);
    fire(1'b1, 1'b0);
    void'(exp_q.pop_front());
    check("wrap_ts_3", bus.trig_ts, 3);
    check("wrap_cnt",  bus.trig_cnt, exp_cnt);
    step();
    check("wrap_freeze", bus.freeze, 8'hFF);

    // async reset while FROZEN
    #2 axi_rst_n = 1'b0;
    #1;
    check("arst_freeze", bus.freeze,   0);
    check("arst_state",  bus.state_o,  0);
    check("arst_cnt",    bus.trig_cnt, 0);
    check("arst_ts",     bus.trig_ts,  0);
    step();
    axi_rst_n = 1'b1;
    exp_cnt = 8'd0;
    step();

    // trig_cnt saturation
    for (int n = 0; n < 300; n++) begin
      pulse_arm();
      bus.sw_trig = 1'b1; step(); bus.sw_trig = 1'b0;
      bump_cnt();
      pulse_release();
    end
    check("sat_cnt",   bus.trig_cnt, 255);
    check("sat_model", bus.trig_cnt, exp_cnt);
    check("sat_state", bus.state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
